uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Frame-level controller for the UART receiver. It detects the start edge on the serial line and drives the edge/bit counter and the data sampler. It uses their counts and sampled bits to walk through the start, data, parity and stop fields. It deserialises the byte, checks parity and stop, and presents the byte with a one-cycle valid pulse to the downstream register/FIFO stage.

## Interface
- No parameters. Frame format is fixed at 1 start bit, 8 data bits LSB-first, optional parity and 1 stop bit.
- clk  input  1  receiver oversampling clock.
- rst  input  1  reset: synchronous, active-high.
- rx_in  input  1  serial line; idles high.
- prescale  input  5  oversampling ratio; legal values 4–15, nominal 8. Must be stable while a frame is in progress.
- par_en  input  1  1 = parity field present.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- bit_cnt  input  4  bit index from the edge/bit counter.
- edge_cnt  input  4  edge index within the current bit, from the edge/bit counter.
- sampled_bit  input  1  resolved bit value from the data sampler.
- cnt_en  output  1  enable to the edge/bit counter.
- cnt_rst  output  1  counter clear, one-cycle pulse.
- samp_en  output  1  enable to the data sampler.
- p_data  output  8  received byte.
- data_valid  output  1  one-cycle pulse when p_data is a good frame.
- par_err  output  1  one-cycle parity-error pulse.
- stp_err  output  1  one-cycle stop-error pulse.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- bit_done = (edge_cnt == prescale[3:0]). This is the last edge of the current bit. sampled_bit is valid in that cycle.
- IDLE: when rx_in == 0, go to START. On that transition:
  - latch par_en and par_typ into internal copies used for the rest of the frame;
  - assert cnt_rst for the first START cycle.
- START: when bit_done, go to DATA. Under the macro, a high sampled_bit instead sends the FSM back to IDLE; see Configuration.
- DATA: when bit_done, shift sampled_bit into bit 7 of the shift register, shifting right. When bit_done and bit_cnt == 8, go to PARITY if latched par_en is 1, otherwise go to STOP.
- PARITY: when bit_done, set par_flag = sampled_bit ^ (^shift_reg) ^ latched par_typ, then go to STOP.
- STOP: when bit_done, set stp_flag = ~sampled_bit, then go to DONE.
- DONE: lasts exactly one cycle, then goes to IDLE.
  - p_data <= shift_reg.
  - data_valid = ~par_flag & ~stp_flag.
  - par_err = par_flag.
  - stp_err = stp_flag.
  - A low rx_in seen in DONE is handled by IDLE on the next cycle, so there is no lost frame at a 1-stop-bit spacing.
- cnt_en and samp_en are high in START, DATA, PARITY and STOP. They are low in IDLE and DONE.
- par_flag and stp_flag clear on IDLE→START. par_flag stays 0 when parity is disabled.
- p_data holds its value until the next DONE, including after an erroneous frame.

## Timing
- All outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.
- Reset: state IDLE, and every output plus all internal registers go to 0.
- Reset has priority over every state transition. A reset mid-frame abandons the frame with no pulses emitted.
- cnt_rst is high for exactly the first START cycle, while cnt_en is also high.
- Latency: data_valid is asserted 1 cycle after the STOP-state bit_done cycle.
- data_valid, par_err and stp_err are never high for more than 1 cycle. They all coincide in the DONE cycle.
- Inputs prescale, par_en and par_typ may change while in IDLE only; changes at other times are undefined.

## Configuration
- UART_RX_START_CHECK_EN defined: in START, if bit_done and sampled_bit == 1, treat it as a glitch:
  - return to IDLE;
  - no pulses, no p_data change;
  - cnt_en drops the next cycle.
- UART_RX_START_CHECK_EN undefined: the start bit is accepted unconditionally, and START always proceeds to DATA at bit_done.

## Test plan
- prescale 8, par_en 1, par_typ 0, byte 0xA5, parity 0, stop 1 → p_data 0xA5, one data_valid pulse, par_err 0, stp_err 0.
- Same frame with par_typ 1 and the parity bit sent as 0 → par_err pulse, data_valid 0, p_data 0xA5.
- par_en 0, byte 0x3C, stop bit driven 0 → stp_err pulse, data_valid 0; the FSM is back in IDLE 1 cycle later.
- Macro defined: rx_in low for 2 cycles, then high through the start bit → FSM returns to IDLE and no pulses occur. Macro undefined: the frame is received as 0xFF with stp_err depending on the line.
- Two back-to-back frames 0x01 then 0x80 with no idle gap → two data_valid pulses, with p_data 0x01 then 0x80.
- Assert rst during DATA at bit_cnt 4 → all outputs 0 the next cycle. A subsequent frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: sequences start/data/parity/stop, deserialises the byte.
// Define UART_RX_START_CHECK_EN to drop start bits that resolve high (glitch rejection).
module uart_rx_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic [4:0] prescale,
   input  logic       par_en,
   input  logic       par_typ,
   input  logic [3:0] bit_cnt,
   input  logic [3:0] edge_cnt,
   input  logic       sampled_bit,
   output logic       cnt_en,
   output logic       cnt_rst,
   output logic       samp_en,
   output logic [7:0] p_data,
   output logic       data_valid,
   output logic       par_err,
   output logic       stp_err
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4,
      StDone   = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic       par_en_q, par_en_d;
   logic       par_typ_q, par_typ_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] p_data_q, p_data_d;
   logic       par_flag_q, par_flag_d;
   logic       cnt_rst_q, cnt_rst_d;
   logic       data_valid_q, data_valid_d;
   logic       par_err_q, par_err_d;
   logic       stp_err_q, stp_err_d;
   logic       bit_done;
   logic       unused_prescale;

   // Only the low nibble is a legal ratio; the top bit is ignored.
   assign unused_prescale = prescale[4];
   assign bit_done        = (edge_cnt == prescale[3:0]);

   always_comb begin
      state_d      = state_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      par_flag_d   = par_flag_q;
      cnt_rst_d    = 1'b0;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_in) begin
               state_d    = StStart;
               par_en_d   = par_en;
               par_typ_d  = par_typ;
               par_flag_d = 1'b0;
               cnt_rst_d  = 1'b1;
            end
         end
         StStart: begin
            if (bit_done) begin
`ifdef UART_RX_START_CHECK_EN
               state_d = sampled_bit ? StIdle : StData;
`else
               state_d = StData;
`endif
            end
         end
         StData: begin
            if (bit_done) begin
               shift_d = {sampled_bit, shift_q[7:1]};
               if (bit_cnt == 4'd8) begin
                  state_d = par_en_q ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (bit_done) begin
               par_flag_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
               state_d    = StStop;
            end
         end
         StStop: begin
            // Pulses are registered here so they land exactly in the DONE cycle.
            if (bit_done) begin
               state_d      = StDone;
               p_data_d     = shift_q;
               par_err_d    = par_flag_q;
               stp_err_d    = ~sampled_bit;
               data_valid_d = ~par_flag_q & sampled_bit;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         shift_q      <= 8'h00;
         p_data_q     <= 8'h00;
         par_flag_q   <= 1'b0;
         cnt_rst_q    <= 1'b0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         par_flag_q   <= par_flag_d;
         cnt_rst_q    <= cnt_rst_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign cnt_en     = (state_q == StStart) || (state_q == StData) ||
                       (state_q == StParity) || (state_q == StStop);
   assign samp_en    = cnt_en;
   assign cnt_rst    = cnt_rst_q;
   assign p_data     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge/bit counter and mid-bit sampler, drives whole frames
// on rx_in and compares the pulses seen against a frame-level reference.
module tb_uart_rx_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [4:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic [3:0] bit_cnt;
   logic [3:0] edge_cnt;
   logic       sampled_bit;
   logic       cnt_en;
   logic       cnt_rst;
   logic       samp_en;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   typedef struct packed {
      logic [7:0] data;
      logic       dv;
      logic       pe;
      logic       se;
   } evt_t;

   evt_t obs_q[$];
   evt_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_pulse = 1'b0;
   logic [3:0] mid;

   always #5 clk = ~clk;

   uart_rx_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .prescale    (prescale),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .bit_cnt     (bit_cnt),
      .edge_cnt    (edge_cnt),
      .sampled_bit (sampled_bit),
      .cnt_en      (cnt_en),
      .cnt_rst     (cnt_rst),
      .samp_en     (samp_en),
      .p_data      (p_data),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err)
   );

   // Edge/bit counter: each bit spans edges 0..prescale.
   always_ff @(posedge clk) begin
      if (rst || !cnt_en) begin
         edge_cnt <= 4'd0;
         bit_cnt  <= 4'd0;
      end else if (cnt_rst) begin
         edge_cnt <= 4'd1;
         bit_cnt  <= 4'd0;
      end else if (edge_cnt == prescale[3:0]) begin
         edge_cnt <= 4'd0;
         bit_cnt  <= bit_cnt + 4'd1;
      end else begin
         edge_cnt <= edge_cnt + 4'd1;
      end
   end

   // Sampler: capture the line near mid-bit, hold it until the bit's last edge.
   assign mid = prescale[3:0] >> 1;
   always_ff @(posedge clk) begin
      if (rst) sampled_bit <= 1'b1;
      else if (edge_cnt == mid) sampled_bit <= rx_in;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cnt_rst) check_eq("cnt_rst_with_en", {31'd0, cnt_en}, 32'd1);
      if (prev_pulse) begin
         check_eq("pulse_width", {29'd0, data_valid, par_err, stp_err}, 32'd0);
         check_eq("idle_after_done", {31'd0, cnt_en}, 32'd0);
      end
      if (data_valid || par_err || stp_err) begin
         obs_q.push_back('{data: p_data, dv: data_valid, pe: par_err, se: stp_err});
         check_eq("done_enables", {30'd0, cnt_en, samp_en}, 32'd0);
      end
      prev_pulse = data_valid | par_err | stp_err;
   end

   // Frame-level expectation: parity bit must make the ones count even (or odd).
   function automatic evt_t ref_frame(input logic [7:0] b, input logic pen, input logic ptyp,
                                      input logic pbit, input logic stop);
      evt_t e;
      int   ones;
      ones = $countones(b) + int'(pbit);
      e.data = b;
      e.pe   = pen && ((ones % 2) != int'(ptyp));
      e.se   = !stop;
      e.dv   = !e.pe && !e.se;
      return e;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stop,
                             input int gap);
      logic [10:0] bits;
      int          n;
      int          p;
      p    = int'(prescale) + 1;
      bits = {2'b11, b, 1'b0};
      if (par_en) begin
         bits[9]  = pbit;
         bits[10] = stop;
         n        = 11;
      end else begin
         bits[9] = stop;
         n       = 10;
      end
      for (int i = 0; i < n; i++) begin
         rx_in = bits[i];
         repeat (p) @(negedge clk);
      end
      rx_in = 1'b1;
      repeat (gap) @(negedge clk);
      exp_q.push_back(ref_frame(b, par_en, par_typ, pbit, stop));
   endtask

   task automatic drain();
      evt_t o;
      evt_t e;
      int   waited = 0;
      while (obs_q.size() < exp_q.size() && waited < 600) begin
         @(negedge clk);
         waited++;
      end
      repeat (40) @(negedge clk);
      check_eq("event_count", obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check_eq("p_data", {24'd0, o.data}, {24'd0, e.data});
         check_eq("data_valid", {31'd0, o.dv}, {31'd0, e.dv});
         check_eq("par_err", {31'd0, o.pe}, {31'd0, e.pe});
         check_eq("stp_err", {31'd0, o.se}, {31'd0, e.se});
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_outs_zero(input string tag);
      check_eq({tag, "_enables"}, {29'd0, cnt_en, cnt_rst, samp_en}, 32'd0);
      check_eq({tag, "_p_data"}, {24'd0, p_data}, 32'd0);
      check_eq({tag, "_pulses"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
   endtask

   task automatic set_cfg(input logic [4:0] ps, input logic pen, input logic ptyp);
      prescale = ps;
      par_en   = pen;
      par_typ  = ptyp;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] bits;
      logic        reached;
      rst      = 1'b1;
      rx_in    = 1'b1;
      prescale = 5'd8;
      par_en   = 1'b0;
      par_typ  = 1'b0;
      repeat (3) @(negedge clk);
      check_outs_zero("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Good even-parity frame, then wrong odd parity, then a stop error.
      set_cfg(5'd8, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 3);
      drain();
      set_cfg(5'd8, 1'b1, 1'b1);
      send_frame(8'hA5, 1'b0, 1'b1, 3);
      drain();
      set_cfg(5'd8, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 3);
      drain();

      // Short low glitch on an idle line.
      rx_in = 1'b0;
      repeat (2) @(negedge clk);
      rx_in = 1'b1;
`ifndef UART_RX_START_CHECK_EN
      exp_q.push_back(ref_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1));
`endif
      drain();

      // Back-to-back frames, no idle gap after the first stop bit.
      set_cfg(5'd8, 1'b0, 1'b0);
      send_frame(8'h01, 1'b0, 1'b1, 0);
      send_frame(8'h80, 1'b0, 1'b1, 3);
      drain();

      for (int k = 0; k < 20; k++) begin
         set_cfg(5'($urandom_range(4, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
         send_frame(8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 5) != 0), $urandom_range(2, 5));
         drain();
      end

      // Reset in the middle of the data field.
      set_cfg(5'd8, 1'b0, 1'b0);
      bits    = {2'b11, 8'hC3, 1'b0};
      reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         rx_in = bits[i];
         for (int c = 0; c < 9 && !reached; c++) begin
            @(negedge clk);
            if (cnt_en && bit_cnt == 4'd4) reached = 1'b1;
         end
      end
      check_eq("reach_bit4", {31'd0, reached}, 32'd1);
      rst   = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      check_outs_zero("midframe_rst");
      rst = 1'b0;
      drain();
      send_frame(8'h55, 1'b0, 1'b1, 3);
      drain();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
